fb_dev_io: RTL and testbench

- Device-register block that sits directly downstream of the address decoder in the MEM stage.
- Consumes the decoded `data_src` select and the `clr_stat` pulse, and implements the three external-device registers: status, keyboard data, and terminal output.
- Buffers keyboard characters in a small FIFO and drives a valid/ready handshake toward the terminal.
- Read data is registered so that it lands in the MEM/WB register one cycle later.

---
 rtl/fb_dev_io_pkg.sv | 24 ++
 rtl/fb_sync_fifo.sv | 52 +++++
 rtl/fb_dev_io.sv | 116 +++++++++++
 tb/tb_fb_dev_io.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fb_dev_io_pkg.sv
// Shared definitions for the MEM-stage device registers: decoded source
// selects, status bit positions and the status count saturation helper.
package fb_dev_io_pkg;

  typedef enum logic [1:0] {
    DSRC_STAT  = 2'b00,
    DSRC_KDATA = 2'b01,
    DSRC_TERM  = 2'b10,
    DSRC_MEM   = 2'b11
  } dsrc_e;

  localparam int ST_RXRDY   = 0;
  localparam int ST_RXOVR   = 1;
  localparam int ST_TXBSY   = 2;
  localparam int ST_TXOVR   = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 3;

  // The status word only has three count bits, so deeper FIFOs report 7.
  function automatic logic [ST_CNT_W-1:0] sat_cnt(input int unsigned cnt);
    return (cnt > 7) ? 3'd7 : ST_CNT_W'(cnt);
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop on the same edge frees a
// slot for a push even when full.
module fb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    dout     = mem_q[rd_ptr_q[AW-1:0]];
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_dev_io.sv
// Device registers behind the MEM-stage address decoder: status, keyboard
// receive FIFO and terminal output with a valid/ready handshake.
module fb_dev_io
  import fb_dev_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      data_src,
  input  logic            clr_stat,
  input  logic            dev_rd,
  input  logic            dev_wr,
  input  logic [7:0]      wr_data,
  output logic [XLEN-1:0] rd_data,
  input  logic            kbd_stb,
  input  logic [7:0]      kbd_char,
  output logic            term_valid,
  output logic [7:0]      term_char,
  input  logic            term_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  dsrc_e           dsrc;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty, kbd_pop, stat_clr, term_wr, tx_ovr_set;
  logic [AW:0]     fifo_count;
  logic [XLEN-1:0] status;

  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            term_valid_q, term_valid_d;
  logic [7:0]      term_char_q, term_char_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            tx_ovr_q, tx_ovr_d;

  fb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (kbd_stb),
    .din   (kbd_char),
    .pop   (kbd_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    dsrc     = dsrc_e'(data_src);
    kbd_pop  = dev_rd && (dsrc == DSRC_KDATA);
    stat_clr = dev_rd && clr_stat && (dsrc == DSRC_STAT);
    term_wr  = dev_wr && (dsrc == DSRC_TERM);

    status                           = '0;
    status[ST_RXRDY]                 = !fifo_empty;
    status[ST_RXOVR]                 = rx_ovr_q;
    status[ST_TXBSY]                 = term_valid_q;
    status[ST_TXOVR]                 = tx_ovr_q;
    status[ST_CNT_LSB +: ST_CNT_W]   = sat_cnt(int'(fifo_count));

    rd_data_d = rd_data_q;
    if (dev_rd) begin
      unique case (dsrc)
        DSRC_STAT:  rd_data_d = status;
        DSRC_KDATA: rd_data_d = fifo_empty ? '0 : XLEN'(fifo_head);
        DSRC_TERM:  rd_data_d = XLEN'(term_char_q);
        default:    rd_data_d = '0;
      endcase
    end

    // A concurrent pop on a full FIFO makes room, so only an unserviced
    // full push counts as an overrun; a new event beats a same-edge clear.
    rx_ovr_d = (rx_ovr_q && !stat_clr) || (kbd_stb && fifo_full && !kbd_pop);

    term_valid_d = term_valid_q;
    term_char_d  = term_char_q;
    tx_ovr_set   = 1'b0;
    if (term_valid_q && term_ready) term_valid_d = 1'b0;
    if (term_wr) begin
      if (!term_valid_q || term_ready) begin
        term_valid_d = 1'b1;
        term_char_d  = wr_data;
      end else begin
        tx_ovr_set = 1'b1;
      end
    end
    tx_ovr_d = (tx_ovr_q && !stat_clr) || tx_ovr_set;
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q    <= '0;
      term_valid_q <= 1'b0;
      term_char_q  <= '0;
      rx_ovr_q     <= 1'b0;
      tx_ovr_q     <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      term_valid_q <= term_valid_d;
      term_char_q  <= term_char_d;
      rx_ovr_q     <= rx_ovr_d;
      tx_ovr_q     <= tx_ovr_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign term_valid = term_valid_q;
  assign term_char  = term_char_q;

endmodule

// File: tb/tb_fb_dev_io.sv
// Directed bench for fb_dev_io: keyboard FIFO, status flags, terminal
// handshake and asynchronous reset, each against hand-computed values.
module tb_fb_dev_io;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      data_src = 2'b11;
  logic            clr_stat = 1'b0;
  logic            dev_rd = 1'b0;
  logic            dev_wr = 1'b0;
  logic [7:0]      wr_data = '0;
  logic [XLEN-1:0] rd_data;
  logic            kbd_stb = 1'b0;
  logic [7:0]      kbd_char = '0;
  logic            term_valid;
  logic [7:0]      term_char;
  logic            term_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  fb_dev_io #(.FIFO_DEPTH(4), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_src   (data_src),
    .clr_stat   (clr_stat),
    .dev_rd     (dev_rd),
    .dev_wr     (dev_wr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .kbd_stb    (kbd_stb),
    .kbd_char   (kbd_char),
    .term_valid (term_valid),
    .term_char  (term_char),
    .term_ready (term_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) assert (!(dev_rd && dev_wr)) else $error("dev_rd and dev_wr both high");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle, so outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kbd(input logic [7:0] ch);
    kbd_stb = 1'b1; kbd_char = ch;
    step();
    kbd_stb = 1'b0;
  endtask

  task automatic rd(input logic [1:0] src);
    dev_rd = 1'b1; data_src = src; clr_stat = (src == 2'b00);
    step();
    dev_rd = 1'b0; clr_stat = 1'b0; data_src = 2'b11;
  endtask

  task automatic wr(input logic [1:0] src, input logic [7:0] d);
    dev_wr = 1'b1; data_src = src; wr_data = d;
    step();
    dev_wr = 1'b0; data_src = 2'b11;
  endtask

  initial begin
    // Reset values.
    #12;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_term_valid", {31'b0, term_valid}, 32'h0);
    check("rst_term_char", {24'b0, term_char}, 32'h0);
    rst_n = 1'b1;
    step();

    // Reset mid-transfer: terminal busy, two characters buffered.
    wr(2'b10, 8'h5A);
    kbd(8'h11);
    kbd(8'h22);
    rd(2'b00);
    check("pre_rst_status", rd_data, 32'h25);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_data", rd_data, 32'h0);
    check("arst_term_valid", {31'b0, term_valid}, 32'h0);
    check("arst_term_char", {24'b0, term_char}, 32'h0);
    #3 rst_n = 1'b1;
    step();
    rd(2'b00);
    check("post_rst_status", rd_data, 32'h0);

    // Keyboard round trip.
    kbd(8'h41);
    kbd(8'h42);
    rd(2'b00); check("rt_status", rd_data, 32'h21);
    rd(2'b01); check("rt_data0", rd_data, 32'h41);
    rd(2'b01); check("rt_data1", rd_data, 32'h42);
    rd(2'b00); check("rt_status_end", rd_data, 32'h0);
    rd(2'b01); check("empty_read", rd_data, 32'h0);

    // Overflow with five strobes into four entries.
    for (int i = 0; i < 5; i++) kbd(8'h30 + 8'(i));
    clr_stat = 1'b1; data_src = 2'b00;
    step();
    clr_stat = 1'b0; data_src = 2'b11;
    check("qual_rd_hold", rd_data, 32'h0);
    rd(2'b00); check("ovf_status", rd_data, 32'h43);
    for (int i = 0; i < 4; i++) begin
      rd(2'b01); check($sformatf("ovf_data%0d", i), rd_data, 32'h30 + i);
    end
    rd(2'b00); check("ovf_status_end", rd_data, 32'h0);

    // Full FIFO: push and pop on the same edge.
    for (int i = 0; i < 4; i++) kbd(8'h60 + 8'(i));
    kbd_stb = 1'b1; kbd_char = 8'h55;
    rd(2'b01);
    kbd_stb = 1'b0;
    check("full_pp_data", rd_data, 32'h60);
    rd(2'b00); check("full_pp_status", rd_data, 32'h41);
    // Overrun on the same edge as the clearing status read: set wins.
    kbd_stb = 1'b1; kbd_char = 8'hEE;
    rd(2'b00);
    kbd_stb = 1'b0;
    check("setwin_rd", rd_data, 32'h41);
    rd(2'b00); check("setwin_status", rd_data, 32'h43);
    rd(2'b01); check("full_pp_d1", rd_data, 32'h61);
    rd(2'b01); check("full_pp_d2", rd_data, 32'h62);
    rd(2'b01); check("full_pp_d3", rd_data, 32'h63);
    rd(2'b01); check("full_pp_d4", rd_data, 32'h55);

    // Empty FIFO: push and pop on the same edge.
    kbd_stb = 1'b1; kbd_char = 8'h77;
    rd(2'b01);
    kbd_stb = 1'b0;
    check("empty_pp_data", rd_data, 32'h0);
    rd(2'b00); check("empty_pp_status", rd_data, 32'h11);
    rd(2'b01); check("empty_pp_drain", rd_data, 32'h77);

    // Terminal backpressure.
    term_ready = 1'b0;
    wr(2'b10, 8'h48);
    check("wr_rd_hold", rd_data, 32'h77);
    repeat (3) step();
    check("tx_hold_valid", {31'b0, term_valid}, 32'h1);
    check("tx_hold_char", {24'b0, term_char}, 32'h48);
    wr(2'b10, 8'h49);
    check("tx_drop_char", {24'b0, term_char}, 32'h48);
    rd(2'b00); check("tx_status", rd_data, 32'h0C);
    rd(2'b10); check("tx_rd_term", rd_data, 32'h48);
    term_ready = 1'b1;
    step();
    term_ready = 1'b0;
    check("tx_accept_valid", {31'b0, term_valid}, 32'h0);
    wr(2'b10, 8'h50);
    term_ready = 1'b1;
    wr(2'b10, 8'h51);
    term_ready = 1'b0;
    check("b2b_valid", {31'b0, term_valid}, 32'h1);
    check("b2b_char", {24'b0, term_char}, 32'h51);
    rd(2'b00); check("b2b_status", rd_data, 32'h04);
    term_ready = 1'b1;
    step();
    term_ready = 1'b0;
    check("b2b_drain_valid", {31'b0, term_valid}, 32'h0);
    rd(2'b11); check("mem_read", rd_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
